// File: rtl/regex_stream_ctx_pkg.sv
// Shared types and helpers for the per-stream regex context block.
package regex_stream_ctx_pkg;

    // Top-level context FSM states
    typedef enum logic [1:0] {
        CTX_CLEAR  = 2'd0,
        CTX_IDLE   = 2'd1,
        CTX_ACTIVE = 2'd2
    } ctx_state_e;

    // Default sizing of the block
    localparam int DEF_STATE_W     = 11;
    localparam int DEF_NUM_STREAMS = 64;
    localparam int DEF_COUNT_W     = 16;

    // Widest counter the saturating helper can handle
    localparam int SAT_MAX_W = 32;

    // Add 'inc' to 'value' but never exceed the all-ones value of a 'width'-bit counter
    function automatic logic [SAT_MAX_W-1:0] sat_inc(
        input logic [SAT_MAX_W-1:0] value,
        input logic                 inc,
        input int unsigned          width
    );
        logic [SAT_MAX_W-1:0] max_val;
        if (width >= SAT_MAX_W) begin
            max_val = '1;
        end else begin
            max_val = (32'd1 << width) - 32'd1;
        end
        if (inc && (value < max_val)) begin
            return value + 32'd1;
        end
        return value;
    endfunction

endpackage

// File: rtl/regex_ctx_clear_walker.sv
// Index walker that sweeps every stream context slot once while a wipe is in progress.
module regex_ctx_clear_walker #(
    parameter int NUM_STREAMS = 64,
    parameter int SID_W       = $clog2(NUM_STREAMS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             busy,
    output logic [SID_W-1:0] idx,
    output logic             last
);

    localparam logic [SID_W-1:0] LAST_IDX = SID_W'(NUM_STREAMS - 1);

    assign last = busy && (idx == LAST_IDX);

    // Reset starts a walk at slot 0; a walk steps one slot per cycle and stops after the last slot
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy <= 1'b1;
            idx  <= '0;
        end else if (busy) begin
            if (idx == LAST_IDX) begin
                busy <= 1'b0;
                idx  <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else if (start) begin
            busy <= 1'b1;
            idx  <= '0;
        end
    end

endmodule

// File: rtl/regex_stream_ctx.sv
// Per-stream context store for an external regex matcher: restores matcher state at
// packet start, commits state and match counts at end of packet, and wipes all contexts.
module regex_stream_ctx
    import regex_stream_ctx_pkg::*;
#(
    parameter int STATE_W     = DEF_STATE_W,
    parameter int NUM_STREAMS = DEF_NUM_STREAMS,
    parameter int SID_W       = $clog2(NUM_STREAMS),
    parameter int COUNT_W     = DEF_COUNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_state,
    input  logic               new_stream_id,
    input  logic [SID_W-1:0]   stream_id,
    input  logic               enable,
    input  logic [7:0]         char_in,
    input  logic               char_in_vld,
    input  logic               eop,
    output logic [7:0]         m_char,
    output logic               m_char_vld,
    output logic [STATE_W-1:0] m_state_in,
    output logic               m_state_in_vld,
    input  logic [STATE_W-1:0] m_state_out,
    input  logic               m_accept,
    output logic               fired,
    output logic [COUNT_W-1:0] total_count,
    input  logic               rd_en,
    input  logic [SID_W-1:0]   rd_sid,
    output logic [COUNT_W-1:0] rd_data,
    output logic               rd_vld,
    input  logic               clr_all,
    output logic               clr_busy
);

    ctx_state_e         state_q;
    ctx_state_e         state_d;

    logic [SID_W-1:0]   sid_q;
    logic               en_q;
    logic               new_q;
    logic               load_vld_q;
    logic               fired_q;
    logic               clr_pend_q;
    logic [COUNT_W-1:0] total_q;
    logic [COUNT_W-1:0] rd_data_q;
    logic               rd_vld_q;

    logic [STATE_W-1:0] state_mem [NUM_STREAMS];
    logic [COUNT_W-1:0] cnt_mem   [NUM_STREAMS];

    logic               load_ok;
    logic               commit;
    logic               walk_start;
    logic               walk_busy;
    logic               walk_last;
    logic [SID_W-1:0]   walk_idx;
    logic               hit;
    logic [COUNT_W-1:0] cnt_cur;
    logic [COUNT_W-1:0] cnt_next;
    logic [COUNT_W-1:0] total_next;

    logic               mem_we;
    logic [SID_W-1:0]   mem_addr;
    logic [STATE_W-1:0] state_wdata;
    logic [COUNT_W-1:0] cnt_wdata;

    regex_ctx_clear_walker #(
        .NUM_STREAMS (NUM_STREAMS),
        .SID_W       (SID_W)
    ) u_walker (
        .clk   (clk),
        .rst_n (rst_n),
        .start (walk_start),
        .busy  (walk_busy),
        .idx   (walk_idx),
        .last  (walk_last)
    );

    // Next-state decode; a wipe request beats a packet start arriving in the same cycle
    always_comb begin
        state_d    = state_q;
        load_ok    = 1'b0;
        walk_start = 1'b0;
        commit     = 1'b0;
        case (state_q)
            CTX_CLEAR: begin
                if (walk_last) begin
                    state_d = CTX_IDLE;
                end
            end
            CTX_IDLE: begin
                if (clr_all) begin
                    state_d = CTX_CLEAR;
                end else if (load_state) begin
                    state_d = CTX_ACTIVE;
                    load_ok = 1'b1;
                end
            end
            CTX_ACTIVE: begin
                commit = eop && en_q;
                if (eop && (clr_pend_q || clr_all)) begin
                    state_d = CTX_CLEAR;
                end else if (load_state) begin
                    state_d = CTX_ACTIVE;
                    load_ok = 1'b1;
                end else if (eop) begin
                    state_d = CTX_IDLE;
                end
            end
            default: begin
                state_d = CTX_CLEAR;
            end
        endcase
        if ((state_q != CTX_CLEAR) && (state_d == CTX_CLEAR)) begin
            walk_start = 1'b1;
        end
    end

    // Commit arithmetic: a match seen earlier in the packet or in the eop cycle itself counts once
    always_comb begin
        hit        = fired_q | m_accept;
        cnt_cur    = cnt_mem[sid_q];
        total_next = COUNT_W'(sat_inc(32'(total_q), hit, COUNT_W));
        if (new_q) begin
            cnt_next = COUNT_W'(hit);
        end else begin
            cnt_next = COUNT_W'(sat_inc(32'(cnt_cur), hit, COUNT_W));
        end
    end

    // Single write port shared by the wipe walk and the end-of-packet commit
    always_comb begin
        mem_we      = 1'b0;
        mem_addr    = sid_q;
        state_wdata = m_state_out;
        cnt_wdata   = cnt_next;
        if (state_q == CTX_CLEAR) begin
            mem_we      = 1'b1;
            mem_addr    = walk_idx;
            state_wdata = '0;
            cnt_wdata   = '0;
        end else if (commit) begin
            mem_we = 1'b1;
        end
    end

    // Context RAMs; writes are blocked while reset is held so an abandoned packet never commits
    always_ff @(posedge clk) begin
        if (rst_n && mem_we) begin
            state_mem[mem_addr] <= state_wdata;
            cnt_mem[mem_addr]   <= cnt_wdata;
        end
    end

    // FSM register plus the stream context latched at packet start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= CTX_CLEAR;
            load_vld_q <= 1'b0;
            sid_q      <= '0;
            en_q       <= 1'b0;
            new_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_vld_q <= load_ok;
            if (load_ok) begin
                sid_q <= stream_id;
                en_q  <= enable;
                new_q <= new_stream_id;
            end
        end
    end

    // Remember a wipe request made mid-packet until that packet ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clr_pend_q <= 1'b0;
        end else if (state_d == CTX_CLEAR) begin
            clr_pend_q <= 1'b0;
        end else if ((state_q == CTX_ACTIVE) && clr_all) begin
            clr_pend_q <= 1'b1;
        end
    end

    // Sticky match flag for the packet in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fired_q <= 1'b0;
        end else if (load_ok) begin
            fired_q <= 1'b0;
        end else if ((state_q == CTX_ACTIVE) && eop && !en_q) begin
            fired_q <= 1'b0;
        end else if ((state_q == CTX_ACTIVE) && m_accept) begin
            fired_q <= 1'b1;
        end
    end

    // Global match counter, zeroed whenever a wipe is entered or running
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            total_q <= '0;
        end else if (state_d == CTX_CLEAR) begin
            total_q <= '0;
        end else if (commit) begin
            total_q <= total_next;
        end
    end

    // Count read port; sampling before the write lands gives the pre-commit value on a collision
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= rd_en && (state_q != CTX_CLEAR);
            if (rd_en && (state_q != CTX_CLEAR)) begin
                rd_data_q <= cnt_mem[rd_sid];
            end
        end
    end

    assign m_char         = char_in;
    assign m_char_vld     = rst_n && (state_q == CTX_ACTIVE) && char_in_vld;
    assign m_state_in_vld = load_vld_q;
    assign m_state_in     = (load_vld_q && !new_q) ? state_mem[sid_q] : '0;
    assign fired          = fired_q;
    assign total_count    = total_q;
    assign rd_data        = rd_data_q;
    assign rd_vld         = rd_vld_q;
    assign clr_busy       = walk_busy;

endmodule
